// File: rtl/vector_pkg.sv
// Shared definitions for the packed-vector receive path.
// Contents:
//   state_e     - unpacker FSM states (EMPTY, LANE_A, LANE_B)
//   LANE_A_SEL  - out_lane value tagging the lane-a beat
//   LANE_B_SEL  - out_lane value tagging the lane-b beat
//   DEFAULT_W   - default recovered lane width
package vector_pkg;

  localparam int unsigned DEFAULT_W = 3;

  localparam logic LANE_A_SEL = 1'b0;
  localparam logic LANE_B_SEL = 1'b1;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    LANE_A = 2'd1,
    LANE_B = 2'd2
  } state_e;

endpackage

// File: rtl/vector_unpacker.sv
// Packed-vector receiver: 2:1 width down-converter.
// Captures one 2W-bit word {~b, ~a} per valid/ready handshake, re-inverts it and
// emits lane a then lane b as two W-bit beats. Counts fully emitted words.
//
// Ports:
//   clk            in   system clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   in_valid       in   packed word offered
//   in_ready       out  block can capture in_data this cycle
//   in_data        in   [2W-1:0] packed word, [W-1:0]=~a, [2W-1:W]=~b
//   out_valid      out  out_data holds a valid lane beat
//   out_ready      in   consumer accepts the beat this cycle
//   out_data       out  [W-1:0] recovered lane value
//   out_lane       out  0 = lane a, 1 = lane b
//   out_last       out  high on the lane-b beat
//   word_count     out  [CNT_W-1:0] completed words, wraps
//   out_or_bitwise out  [W-1:0] a | b            (only with VECTOR_UNPACK_OR_EN)
//   out_or_logical out  (a != 0) || (b != 0)     (only with VECTOR_UNPACK_OR_EN)
//
// Optional feature macro: VECTOR_UNPACK_OR_EN adds the two OR-reduction outputs.
module vector_unpacker
  import vector_pkg::*;
#(
  parameter int unsigned W     = DEFAULT_W,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*W-1:0]   in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic             out_lane,
  output logic             out_last,
`ifdef VECTOR_UNPACK_OR_EN
  output logic [W-1:0]     out_or_bitwise,
  output logic             out_or_logical,
`endif
  output logic [CNT_W-1:0] word_count
);

  state_e             state_q, state_d;
  logic [2*W-1:0]     buf_q, buf_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               valid_q, valid_d;
  logic [W-1:0]       data_q, data_d;
  logic               lane_q, lane_d;
  logic               last_q, last_d;
  logic               capture;

  // Gated by rst_n so the producer never sees ready during reset.
  assign in_ready = rst_n & ((state_q == EMPTY) | ((state_q == LANE_B) & out_ready));
  assign capture  = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    count_d = count_q;
    unique case (state_q)
      EMPTY: begin
        if (capture) begin
          state_d = LANE_A;
          buf_d   = in_data;
        end
      end
      LANE_A: begin
        if (out_ready) state_d = LANE_B;
      end
      LANE_B: begin
        if (out_ready) begin
          count_d = count_q + CNT_W'(1);
          if (capture) begin
            // Back-to-back: the next word's lane a follows with no bubble.
            state_d = LANE_A;
            buf_d   = in_data;
          end else begin
            state_d = EMPTY;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Outputs are registered, so derive them from the next state and buffer.
  always_comb begin
    valid_d = 1'b0;
    data_d  = '0;
    lane_d  = LANE_A_SEL;
    last_d  = 1'b0;
    unique case (state_d)
      LANE_A: begin
        valid_d = 1'b1;
        data_d  = ~buf_d[W-1:0];
        lane_d  = LANE_A_SEL;
      end
      LANE_B: begin
        valid_d = 1'b1;
        data_d  = ~buf_d[2*W-1:W];
        lane_d  = LANE_B_SEL;
        last_d  = 1'b1;
      end
      default: begin
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      buf_q   <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      lane_q  <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      count_q <= count_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      lane_q  <= lane_d;
      last_q  <= last_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_data   = data_q;
  assign out_lane   = lane_q;
  assign out_last   = last_q;
  assign word_count = count_q;

`ifdef VECTOR_UNPACK_OR_EN
  logic [W-1:0] or_bw_q, or_bw_d;
  logic         or_lg_q, or_lg_d;

  // Computed from the recovered lanes at capture; held until the next word.
  always_comb begin
    or_bw_d = or_bw_q;
    or_lg_d = or_lg_q;
    if (capture) begin
      or_bw_d = ~in_data[W-1:0] | ~in_data[2*W-1:W];
      or_lg_d = (|(~in_data[W-1:0])) || (|(~in_data[2*W-1:W]));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      or_bw_q <= '0;
      or_lg_q <= 1'b0;
    end else begin
      or_bw_q <= or_bw_d;
      or_lg_q <= or_lg_d;
    end
  end

  assign out_or_bitwise = or_bw_q;
  assign out_or_logical = or_lg_q;
`endif

endmodule

// File: tb/tb_vector_unpacker.sv
// Self-checking bench for vector_unpacker: directed table, hand-written corner
// sequences (backpressure, reset in lane b, counter wrap) and a randomized run
// checked against a beat-queue reference model.
module tb_vector_unpacker;

  localparam int unsigned W = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [5:0]   in_data = '0;
  logic         out_ready = 1'b0;
  logic         in_ready, in_ready2;
  logic         out_valid, out_valid2;
  logic [2:0]   out_data, out_data2;
  logic         out_lane, out_lane2;
  logic         out_last, out_last2;
  logic [7:0]   word_count;
  logic [1:0]   word_count2;
`ifdef VECTOR_UNPACK_OR_EN
  logic [2:0]   or_bw, or_bw2;
  logic         or_lg, or_lg2;
`endif

  int n_vec = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  vector_unpacker #(.W(W), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_lane(out_lane),
    .out_last(out_last),
`ifdef VECTOR_UNPACK_OR_EN
    .out_or_bitwise(or_bw), .out_or_logical(or_lg),
`endif
    .word_count(word_count)
  );

  // Narrow counter instance sharing the same stimulus, for wrap checking.
  vector_unpacker #(.W(W), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2), .out_lane(out_lane2),
    .out_last(out_last2),
`ifdef VECTOR_UNPACK_OR_EN
    .out_or_bitwise(or_bw2), .out_or_logical(or_lg2),
`endif
    .word_count(word_count2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       iv;
    logic [5:0] d;
    logic       ordy;
    logic       ev;
    logic [2:0] ed;
    logic       el;
    logic       elast;
    logic       erdy;
    logic [7:0] ecnt;
    logic [2:0] eorb;
    logic       eorl;
  } vec_t;

  function automatic vec_t mk(logic iv, logic [5:0] d, logic ordy, logic ev, logic [2:0] ed,
                              logic el, logic elast, logic erdy, logic [7:0] ecnt,
                              logic [2:0] eorb, logic eorl);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy; v.ev = ev; v.ed = ed; v.el = el; v.elast = elast;
    v.erdy = erdy; v.ecnt = ecnt; v.eorb = eorb; v.eorl = eorl;
    return v;
  endfunction

  typedef struct {
    logic [2:0] data;
    logic       lane;
    logic       last;
    logic [2:0] orb;
    logic       orl;
  } beat_t;

  beat_t model_q[$];
  int    model_cnt;

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    rst_n = 1'b0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
    model_q.delete();
    model_cnt = 0;
  endtask

  task automatic check_or(input string name, input logic [2:0] eorb, input logic eorl);
`ifdef VECTOR_UNPACK_OR_EN
    chk({name, "_or_bw"}, 32'(or_bw), 32'(eorb));
    chk({name, "_or_lg"}, 32'(or_lg), 32'(eorl));
`else
    if (eorb === 3'bx && eorl === 1'bx) $display("unreachable");
`endif
  endtask

  vec_t tbl[12];

  initial begin
    // Reset asserted mid-cycle at time 0.
    #3;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_lane", 32'(out_lane), 0);
    chk("rst_out_last", 32'(out_last), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_count", 32'(word_count), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 1);
    chk("post_rst_out_valid", 32'(out_valid), 0);

    // Directed table: one entry per cycle, inputs at negedge, outputs checked 1ns later.
    tbl[0]  = mk(1, 6'b110_101, 1, 0, 3'b000, 0, 0, 1, 0, 3'b000, 0);
    tbl[1]  = mk(0, 6'b000_000, 0, 1, 3'b010, 0, 0, 0, 0, 3'b011, 1);
    tbl[2]  = mk(0, 6'b000_000, 0, 1, 3'b010, 0, 0, 0, 0, 3'b011, 1);
    tbl[3]  = mk(1, 6'b000_000, 0, 1, 3'b010, 0, 0, 0, 0, 3'b011, 1);
    tbl[4]  = mk(0, 6'b000_000, 1, 1, 3'b010, 0, 0, 0, 0, 3'b011, 1);
    tbl[5]  = mk(0, 6'b000_000, 0, 1, 3'b001, 1, 1, 0, 0, 3'b011, 1);
    tbl[6]  = mk(1, 6'b011_100, 1, 1, 3'b001, 1, 1, 1, 0, 3'b011, 1);
    tbl[7]  = mk(1, 6'b111_111, 1, 1, 3'b011, 0, 0, 0, 1, 3'b111, 1);
    tbl[8]  = mk(1, 6'b111_111, 1, 1, 3'b100, 1, 1, 1, 1, 3'b111, 1);
    tbl[9]  = mk(0, 6'b000_000, 1, 1, 3'b000, 0, 0, 0, 2, 3'b000, 0);
    tbl[10] = mk(0, 6'b000_000, 1, 1, 3'b000, 1, 1, 1, 2, 3'b000, 0);
    tbl[11] = mk(0, 6'b000_000, 1, 0, 3'b000, 0, 0, 1, 3, 3'b000, 0);

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      in_valid = tbl[i].iv;
      in_data = tbl[i].d;
      out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].erdy));
      chk($sformatf("tbl%0d_count", i), 32'(word_count), 32'(tbl[i].ecnt));
      chk($sformatf("tbl%0d_count2", i), 32'(word_count2), 32'(tbl[i].ecnt[1:0]));
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_data", i), 32'(out_data), 32'(tbl[i].ed));
        chk($sformatf("tbl%0d_lane", i), 32'(out_lane), 32'(tbl[i].el));
        chk($sformatf("tbl%0d_last", i), 32'(out_last), 32'(tbl[i].elast));
        if (tbl[i].elast) check_or($sformatf("tbl%0d", i), tbl[i].eorb, tbl[i].eorl);
      end
    end

    // Reset while in LANE_B: one word completed, second word half-emitted.
    do_reset();
    @(negedge clk); in_valid = 1; in_data = 6'b110_101; out_ready = 1;
    @(negedge clk); in_valid = 0;
    @(negedge clk);
    @(negedge clk); in_valid = 1; in_data = 6'b011_100;
    @(negedge clk); in_valid = 0;
    @(negedge clk); out_ready = 0;
    #1;
    chk("lb_pre_count", 32'(word_count), 1);
    chk("lb_pre_last", 32'(out_last), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("lb_rst_valid", 32'(out_valid), 0);
    chk("lb_rst_count", 32'(word_count), 0);
    chk("lb_rst_last", 32'(out_last), 0);
    chk("lb_rst_in_ready", 32'(in_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("lb_after%0d_valid", i), 32'(out_valid), 0);
    end

    // Counter wrap: five back-to-back words with out_ready held high.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      in_valid = (i < 9);
      in_data = 6'(i);
      #1;
      if (i >= 1 && i <= 10) chk($sformatf("wrap_beat%0d_valid", i), 32'(out_valid), 1);
    end
    in_valid = 1'b0;
    chk("wrap_count8", 32'(word_count), 5);
    chk("wrap_count2", 32'(word_count2), 1);
    chk("wrap_idle", 32'(out_valid), 0);

    // Randomized run against the beat-queue model.
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic [5:0] d;
      logic       exp_rdy;
      logic [2:0] a, b;
      beat_t      ba, bb;
      @(negedge clk);
      d = 6'($urandom);
      in_valid = ($urandom_range(0, 3) != 0);
      in_data = d;
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_rdy = (model_q.size() == 0) || (model_q.size() == 1 && out_ready);
      chk("rnd_valid", 32'(out_valid), 32'(model_q.size() != 0));
      chk("rnd_in_ready", 32'(in_ready), 32'(exp_rdy));
      chk("rnd_count", 32'(word_count), 32'(model_cnt % 256));
      chk("rnd_count2", 32'(word_count2), 32'(model_cnt % 4));
      if (model_q.size() != 0) begin
        chk("rnd_data", 32'(out_data), 32'(model_q[0].data));
        chk("rnd_lane", 32'(out_lane), 32'(model_q[0].lane));
        chk("rnd_last", 32'(out_last), 32'(model_q[0].last));
        if (model_q[0].last) check_or("rnd", model_q[0].orb, model_q[0].orl);
        if (out_ready) begin
          if (model_q[0].last) model_cnt++;
          void'(model_q.pop_front());
        end
      end
      if (in_valid && exp_rdy) begin
        a = ~d[2:0];
        b = ~d[5:3];
        ba = '{data: a, lane: 1'b0, last: 1'b0, orb: a | b, orl: (a != 0) || (b != 0)};
        bb = '{data: b, lane: 1'b1, last: 1'b1, orb: a | b, orl: (a != 0) || (b != 0)};
        model_q.push_back(ba);
        model_q.push_back(bb);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
